// File: rtl/mem_arbiter_if.sv
// Per-master memory bus: request, write data and lock from the master;
// waitrequest and read return from the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] wrdata;
  logic              lock;
  logic              waitrequest;
  logic [DATA_W-1:0] rddata;
  logic              rddatavalid;

  modport master (
    output addr, rd, wr, wrdata, lock,
    input  waitrequest, rddata, rddatavalid
  );

  modport slave (
    input  addr, rd, wr, wrdata, lock,
    output waitrequest, rddata, rddatavalid
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port data memory with optional ownership lock.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to master 0.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      m0,
  mem_arbiter_if.slave      m1,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [DATA_W-1:0] o_mem_wrdata,
  input  logic [DATA_W-1:0] i_mem_rddata
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_M0   = 2'd1,
    LOCK_M1   = 2'd2
  } lock_e;

  lock_e lock_q;
  logic  last_grant_q;
  logic  rd_pending_q;
  logic  rd_owner_q;

  logic  req0, req1;
  logic  grant0, grant1;
  logic  tie_to_m1;
  logic  acc_rd;

  always_comb begin
    req0      = m0.rd | m0.wr;
    req1      = m1.rd | m1.wr;
    tie_to_m1 = RR_EN & ~last_grant_q;
    grant0    = 1'b0;
    grant1    = 1'b0;
    // No grant while in reset, so waitrequest simply mirrors the request.
    if (reset) begin
      unique case (lock_q)
        LOCK_M0: grant0 = req0;
        LOCK_M1: grant1 = req1;
        default: begin
          if (req0 && req1) begin
            grant1 = tie_to_m1;
            grant0 = ~tie_to_m1;
          end else begin
            grant0 = req0;
            grant1 = req1;
          end
        end
      endcase
    end
  end

  always_comb begin
    o_mem_addr   = '0;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_mem_wrdata = '0;
    if (grant0) begin
      o_mem_addr   = m0.addr;
      o_mem_wr     = m0.wr;
      o_mem_rd     = m0.rd & ~m0.wr;
      o_mem_wrdata = m0.wrdata;
    end else if (grant1) begin
      o_mem_addr   = m1.addr;
      o_mem_wr     = m1.wr;
      o_mem_rd     = m1.rd & ~m1.wr;
      o_mem_wrdata = m1.wrdata;
    end
  end

  always_comb begin
    acc_rd         = (grant0 & m0.rd & ~m0.wr) | (grant1 & m1.rd & ~m1.wr);
    m0.waitrequest = req0 & ~grant0;
    m1.waitrequest = req1 & ~grant1;
    m0.rddata      = i_mem_rddata;
    m1.rddata      = i_mem_rddata;
    m0.rddatavalid = rd_pending_q & ~rd_owner_q;
    m1.rddatavalid = rd_pending_q &  rd_owner_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
      last_grant_q <= 1'b1;
      lock_q       <= LOCK_NONE;
    end else begin
      rd_pending_q <= acc_rd;
      if (acc_rd) begin
        rd_owner_q <= grant1;
      end
      if (grant0 || grant1) begin
        last_grant_q <= grant1;
      end
      // Acquiring takes precedence; release is checked on the lock input alone.
      if (grant0 && m0.lock) begin
        lock_q <= LOCK_M0;
      end else if (grant1 && m1.lock) begin
        lock_q <= LOCK_M1;
      end else if (lock_q == LOCK_M0 && !m0.lock) begin
        lock_q <= LOCK_NONE;
      end else if (lock_q == LOCK_M1 && !m1.lock) begin
        lock_q <= LOCK_NONE;
      end
    end
  end

endmodule
